// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and FSM state type for the instruction fetch unit
package fetch_pkg;

    localparam int DEF_ADDR_W      = 24;
    localparam int DEF_INSTR_W     = 24;
    localparam int DEF_INSTR_BYTES = 3;
    localparam int DEF_RESET_VEC   = 0;
    localparam int DEF_BUF_DEPTH   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small power-of-two FIFO holding fetched {pc, instr} entries
module fetch_buffer #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // a push into a full buffer is only legal when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop) & ~flush;

    assign head_data = mem[rd_ptr];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetcher with redirect and a small decode buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int INSTR_BYTES = DEF_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter int BUF_DEPTH   = DEF_BUF_DEPTH
) (
    input  logic               Clock,
    input  logic               Resetn,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_next
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_BYTES);

    fetch_state_t        state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_after;
    logic                buf_empty;
    logic                push;
    logic                pop;
    logic                space_after;
    logic [ADDR_W-1:0]   next_seq;
    logic [ADDR_W+INSTR_W-1:0] head;

    // a redirect kills both the head consumption and any response landing this cycle
    assign pop         = instr_valid & instr_ready & ~redirect;
    assign push        = (state == WAIT) & imem_ack & ~redirect;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign space_after = (count_after < CNT_W'(BUF_DEPTH));
    assign next_seq    = imem_addr + PC_INC;

    fetch_buffer #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .push      (push),
        .push_data ({imem_addr, imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head_data (head),
        .count     (count),
        .empty     (buf_empty)
    );

    assign instr_valid   = ~buf_empty;
    assign instr_pc      = head[ADDR_W+INSTR_W-1:INSTR_W];
    assign instr_data    = head[INSTR_W-1:0];
    assign instr_pc_next = instr_pc + PC_INC;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state     <= IDLE;
            fetch_pc  <= RESET_VEC;
            imem_addr <= RESET_VEC;
            imem_req  <= 1'b0;
        end else begin
            if (redirect) fetch_pc <= redirect_pc;
            case (state)
                IDLE: begin
                    if (redirect) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_pc;
                    end else if (space_after) begin
                        state     <= WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        // the bus cannot cancel, so an unanswered request is drained in DISCARD
                        if (imem_ack) imem_addr <= redirect_pc;
                        else          state     <= DISCARD;
                    end else if (imem_ack) begin
                        fetch_pc <= next_seq;
                        if (space_after) begin
                            imem_addr <= next_seq;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state     <= WAIT;
                        imem_addr <= redirect ? redirect_pc : fetch_pc;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-controlled memory model
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        imem_req;
    logic [23:0] imem_addr;
    logic        imem_ack;
    logic [23:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [23:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [23:0] instr_data;
    logic [23:0] instr_pc;
    logic [23:0] instr_pc_next;

    fetch_unit dut (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_pc_next (instr_pc_next)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mem_data(input logic [23:0] a);
        return a ^ 24'hA5C3F0;
    endfunction

    // memory: acks a held request after mem_lat extra cycles; stray_ack is driven by hand
    bit   mem_en = 1'b0;
    int   mem_lat = 0;
    int   wait_cnt = 0;
    logic auto_ack = 1'b0;
    logic stray_ack = 1'b0;

    assign imem_ack   = auto_ack | stray_ack;
    assign imem_rdata = stray_ack ? 24'h5A5A5A : mem_data(imem_addr);

    always @(posedge Clock) begin
        #1;
        auto_ack = 1'b0;
        if (!Resetn || !mem_en) begin
            wait_cnt = 0;
        end else if (imem_req) begin
            if (wait_cnt >= mem_lat) begin
                auto_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // scoreboard: expected fetch addresses pushed on accepted acks, popped on consumption
    logic [23:0] sb_q[$];
    logic [23:0] exp_pc;
    bit          discard_pending = 1'b0;

    always @(negedge Clock) begin
        if (!Resetn) begin
            sb_q.delete();
            discard_pending = 1'b0;
        end else begin
            check("valid", {31'd0, instr_valid}, {31'd0, sb_q.size() != 0});
            if (instr_valid && instr_ready && !redirect && sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                check("head_pc", {8'd0, instr_pc}, {8'd0, exp_pc});
                check("head_data", {8'd0, instr_data}, {8'd0, mem_data(exp_pc)});
                check("head_pc_next", {8'd0, instr_pc_next}, {8'd0, exp_pc + 24'd3});
            end
            if (imem_ack && imem_req) begin
                if (!redirect && !discard_pending) sb_q.push_back(imem_addr);
                discard_pending = 1'b0;
            end
            if (redirect) begin
                sb_q.delete();
                if (imem_req && !imem_ack) discard_pending = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(posedge Clock);
        #1 Resetn = 1'b0;
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_addr", {8'd0, imem_addr}, 32'd0);
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
    endtask

    task automatic wait_addr(input string tag, input logic [23:0] target, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge Clock);
            if (imem_req && imem_addr == target) break;
        end
        check(tag, {8'd0, imem_addr}, {8'd0, target});
    endtask

    task automatic first_req(input string tag, input logic [23:0] target, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge Clock);
            if (imem_req) break;
        end
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check(tag, {8'd0, imem_addr}, {8'd0, target});
    endtask

    int held;

    initial begin
        // sequential streaming with single-cycle memory
        mem_en = 1'b1; mem_lat = 0; instr_ready = 1'b1;
        do_reset();
        @(negedge Clock);
        check("a_req_before_edge", {31'd0, imem_req}, 32'd0);
        @(negedge Clock);
        check("a_first_req", {31'd0, imem_req}, 32'd1);
        check("a_addr_0", {8'd0, imem_addr}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clock);
            check("a_addr_seq", {8'd0, imem_addr}, 32'(3 * i));
        end
        repeat (6) @(negedge Clock);

        // redirect near the top of the address space, then wrap
        @(posedge Clock);
        #1 mem_en = 1'b0;
        repeat (3) @(posedge Clock);
        #1 redirect = 1'b1; redirect_pc = 24'hFFFFFE;
        @(posedge Clock);
        #1 redirect = 1'b0; mem_en = 1'b1;
        wait_addr("b_wrap_addr", 24'h000001, 20);

        // back-pressure fills the two-entry buffer, then release
        instr_ready = 1'b0;
        do_reset();
        repeat (8) @(negedge Clock);
        check("c_idle_req", {31'd0, imem_req}, 32'd0);
        check("c_full_valid", {31'd0, instr_valid}, 32'd1);
        check("c_head_pc", {8'd0, instr_pc}, 32'd0);
        @(posedge Clock);
        #1 instr_ready = 1'b1;
        first_req("c_next_addr", 24'd6, 10);

        // redirect while a slow request is outstanding
        mem_lat = 3;
        do_reset();
        wait_addr("d_reach_9", 24'h000009, 40);
        @(posedge Clock);
        #1 redirect = 1'b1; redirect_pc = 24'h000100;
        @(posedge Clock);
        #1 redirect = 1'b0;
        held = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (imem_addr != 24'h000009) break;
            held++;
            check("d_hold_req", {31'd0, imem_req}, 32'd1);
            check("d_hold_empty", {31'd0, instr_valid}, 32'd0);
        end
        check("d_held_some", {31'd0, held >= 1}, 32'd1);
        check("d_redirect_addr", {8'd0, imem_addr}, 32'h000100);

        // redirect, ack and pop all in one cycle
        mem_lat = 0;
        repeat (6) @(posedge Clock);
        #1 redirect = 1'b1; redirect_pc = 24'h000200;
        @(negedge Clock);
        check("e_pre_valid", {31'd0, instr_valid}, 32'd1);
        check("e_pre_req", {31'd0, imem_req}, 32'd1);
        @(posedge Clock);
        #1 redirect = 1'b0;
        @(negedge Clock);
        check("e_flushed", {31'd0, instr_valid}, 32'd0);
        check("e_addr", {8'd0, imem_addr}, 32'h000200);

        // reset mid-request, stray ack after release
        @(posedge Clock);
        #1 mem_en = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Resetn = 1'b0;
        #1;
        check("f_rst_req", {31'd0, imem_req}, 32'd0);
        check("f_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("f_rst_addr", {8'd0, imem_addr}, 32'd0);
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1; stray_ack = 1'b1;
        @(negedge Clock);
        check("f_pre_req", {31'd0, imem_req}, 32'd0);
        @(posedge Clock);
        #1 stray_ack = 1'b0; mem_en = 1'b1;
        @(negedge Clock);
        check("f_first_req", {31'd0, imem_req}, 32'd1);
        check("f_first_addr", {8'd0, imem_addr}, 32'd0);
        repeat (10) @(negedge Clock);

        @(posedge Clock);
        #1 mem_en = 1'b0;
        repeat (6) @(negedge Clock);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 24, PC/address width
- INSTR_W, 24, instruction width
- INSTR_BYTES, 3, sequential PC increment
- RESET_VEC, 0, PC value after reset
- BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

REQ-002 Ports SHALL be (name direction width meaning):
- Clock  in  1  single clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1
- imem_ack  in  1  one-cycle pulse, response valid
- imem_rdata  in  INSTR_W  instruction, valid with imem_ack
- redirect  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  ADDR_W  new PC, valid with redirect
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode consumes head
- instr_data  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  address of head instruction
- instr_pc_next  out  ADDR_W  instr_pc + INSTR_BYTES (link value)

Function
REQ-003 The block SHALL hold fetch_pc (the next address to request) and a FIFO of BUF_DEPTH entries {pc, instr}.
REQ-004 The FSM SHALL have states IDLE (no request outstanding), WAIT (request outstanding), and DISCARD (outstanding request whose response must be dropped).
REQ-005 imem_req SHALL be registered and equal 1 exactly in WAIT and DISCARD; imem_addr SHALL be registered and hold the outstanding request's address.
REQ-006 IDLE->WAIT SHALL occur when the FIFO has at least one free entry after this cycle's pop; imem_addr<=fetch_pc.
REQ-007 On imem_ack in WAIT, {imem_addr, imem_rdata} SHALL be pushed and fetch_pc<=imem_addr+INSTR_BYTES modulo 2^ADDR_W.
- The next state SHALL be WAIT, requesting the new fetch_pc, if a free entry remains after the push and pop; otherwise IDLE.
REQ-008 imem_ack in IDLE SHALL be ignored.
REQ-009 On imem_ack in DISCARD, the response SHALL be dropped and the FSM SHALL go to WAIT with imem_addr<=fetch_pc.
REQ-010 On redirect, the FIFO SHALL flush and fetch_pc<=redirect_pc. A same-cycle pop SHALL be ignored.
- In IDLE: the FSM SHALL go to WAIT with imem_addr<=redirect_pc.
- In WAIT without ack: the FSM SHALL go to DISCARD; imem_req and imem_addr SHALL be held.
- In WAIT with ack: the data SHALL be dropped and the FSM SHALL go to WAIT with imem_addr<=redirect_pc.
- In DISCARD without ack: the FSM SHALL stay in DISCARD (last redirect wins).
- In DISCARD with ack: the FSM SHALL go to WAIT with imem_addr<=redirect_pc.
REQ-011 instr_valid SHALL be 1 iff the FIFO is non-empty.
- Pop SHALL occur on instr_valid&instr_ready.
- Simultaneous push and pop on a full FIFO SHALL be legal and keep the count.
REQ-012 Push-to-instr_valid latency SHALL be 1 cycle, so the minimum ack-to-consume time is 1 cycle.
REQ-013 Head outputs SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-014 PC arithmetic SHALL wrap modulo 2^ADDR_W. No alignment check SHALL be performed.

Reset
REQ-015 Asserting Resetn=0 SHALL, asynchronously, set:
- fetch_pc=RESET_VEC, imem_addr=RESET_VEC
- FSM=IDLE, imem_req=0
- FIFO empty, instr_valid=0
REQ-016 The first imem_req SHALL rise one cycle after the first rising edge with Resetn=1.
REQ-017 A reset mid-request SHALL abandon the transaction; a later stray ack SHALL be ignored per REQ-008.

Structure
REQ-018 Package fetch_pkg SHALL hold the FSM state enum (IDLE/WAIT/DISCARD) and the default parameter constants.
REQ-019 The FIFO SHALL be a sub-module fetch_buffer with push, pop, flush, and count, parametrised by width and depth.
REQ-020 The implementation target SHALL be 150-300 lines of RTL.

Verification
REQ-021 Reset release, memory acks 1 cycle after every req, instr_ready=1 -> imem_addr 0,3,6,9...; instr_pc follows one fetch behind; instr_pc_next=instr_pc+3.
REQ-022 instr_ready=0, BUF_DEPTH=2 -> two pushes (pc 0,3), then imem_req=0 in IDLE. Set instr_ready=1 -> the next request is issued at address 6.
REQ-023 redirect to 0x000100 while WAIT holds addr 0x000009 with ack delayed 3 cycles -> imem_addr stays 9 until ack, ack data dropped, next imem_addr=0x000100, FIFO empty meanwhile.
REQ-024 redirect and imem_ack in the same cycle, plus a simultaneous pop -> no push, FIFO empty, next imem_addr=redirect_pc.
REQ-025 ADDR_W=24, fetch_pc=0xFFFFFE, ack -> next imem_addr=0x000001 (wrap).
REQ-026 Resetn=0 while in WAIT, released, stray ack in IDLE -> no push; first req at RESET_VEC one cycle after release.
